// File: rtl/disp_pkg.sv
// Shared constants for the 7-segment display path: widths, blank level and the
// ABCDEFG (active-low, A = bit 6) glyph patterns used by the lookup encoder.
package disp_pkg;

  localparam int unsigned SEG_WIDTH    = 7;
  localparam int unsigned NDIG_DEFAULT = 8;
  localparam logic [6:0]  SEG_OFF      = 7'h7F;

  localparam logic [6:0] PAT_BLANK  = 7'h7F;
  localparam logic [6:0] PAT_HYPHEN = 7'h7E;
  localparam logic [6:0] PAT_A      = 7'h08;
  localparam logic [6:0] PAT_C      = 7'h31;
  localparam logic [6:0] PAT_E      = 7'h30;
  localparam logic [6:0] PAT_F      = 7'h38;
  localparam logic [6:0] PAT_H      = 7'h48;
  localparam logic [6:0] PAT_L      = 7'h71;
  localparam logic [6:0] PAT_P      = 7'h18;

  typedef enum logic {PhBlank, PhShow} phase_e;

  // Counter width that stays >= 1 even for a range of one.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot counter and digit index for the display scanner; flags the blank phase,
// the frame wrap (last slot of last digit) and a registered frame_done pulse.
module scan_timer import disp_pkg::*; #(
  parameter int unsigned NDIG         = NDIG_DEFAULT,
  parameter int unsigned DIG_PERIOD   = 100000,
  parameter int unsigned BLANK_CYCLES = 256
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
`ifdef DISP_DIM_EN
  output logic [width_of(DIG_PERIOD)-1:0] cnt,
`endif
  output logic [width_of(NDIG)-1:0]       idx,
  output logic                            blank,
  output logic                            wrap,
  output logic                            frame_done
);

  localparam int unsigned CntW = width_of(DIG_PERIOD);
  localparam int unsigned IdxW = width_of(NDIG);

  logic [CntW-1:0] cnt_q;
  logic [IdxW-1:0] idx_q;
  logic            fd_q;
  logic            slot_end;

  assign slot_end = (cnt_q == CntW'(DIG_PERIOD - 1));
  assign wrap     = enable & slot_end & (idx_q == IdxW'(NDIG - 1));
  assign blank    = (cnt_q < CntW'(BLANK_CYCLES));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      fd_q  <= 1'b0;
    end else if (!enable) begin
      // Parked at the start of digit 0 so re-enable begins with a blank phase.
      cnt_q <= '0;
      idx_q <= '0;
      fd_q  <= 1'b0;
    end else begin
      fd_q <= wrap;
      if (slot_end) begin
        cnt_q <= '0;
        idx_q <= (idx_q == IdxW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef DISP_DIM_EN
  assign cnt = cnt_q;
`endif
  assign idx        = idx_q;
  assign frame_done = fd_q;

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed 8-digit 7-segment driver with blanking and frame-synchronous
// data updates. Define DISP_DIM_EN to add the 4-bit bright PWM input.
module display_scanner import disp_pkg::*; #(
  parameter int unsigned NDIG         = NDIG_DEFAULT,
  parameter int unsigned DIG_PERIOD   = 100000,
  parameter int unsigned BLANK_CYCLES = 256
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      load,
  input  logic [SEG_WIDTH*NDIG-1:0] patterns,
  input  logic [NDIG-1:0]           points,
`ifdef DISP_DIM_EN
  input  logic [3:0]                bright,
`endif
  output logic [SEG_WIDTH-1:0]      segment,
  output logic                      dp,
  output logic [NDIG-1:0]           digit,
  output logic                      frame_done
);

  localparam int unsigned IdxW = width_of(NDIG);

  logic [IdxW-1:0] idx;
  logic            blank;
  logic            wrap;

`ifdef DISP_DIM_EN
  localparam int unsigned CntW = width_of(DIG_PERIOD);
  logic [CntW-1:0] cnt;
  logic [3:0]      pwm_phase;
`endif

  scan_timer #(
    .NDIG         (NDIG),
    .DIG_PERIOD   (DIG_PERIOD),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
`ifdef DISP_DIM_EN
    .cnt        (cnt),
`endif
    .idx        (idx),
    .blank      (blank),
    .wrap       (wrap),
    .frame_done (frame_done)
  );

  logic [NDIG-1:0][SEG_WIDTH-1:0] pat_in;
  logic [NDIG-1:0][SEG_WIDTH-1:0] hold_pat_q, hold_pat_d, shad_pat_q, shad_pat_d;
  logic [NDIG-1:0]                hold_pt_q, hold_pt_d, shad_pt_q, shad_pt_d;
  logic                           pending_q, pending_d;
  logic                           commit;
  phase_e                         phase;
  logic                           lit;
  logic [NDIG-1:0]                digit_d;
  logic [SEG_WIDTH-1:0]           segment_d;
  logic                           dp_d;

  assign pat_in = patterns;
  // A disabled display has no frame to tear, so shadow may follow every cycle.
  assign commit = ~enable | wrap;

  always_comb begin
    hold_pat_d = hold_pat_q;
    hold_pt_d  = hold_pt_q;
    shad_pat_d = shad_pat_q;
    shad_pt_d  = shad_pt_q;
    pending_d  = pending_q;
    if (load) begin
      hold_pat_d = pat_in;
      hold_pt_d  = points;
    end
    if (commit) begin
      pending_d = 1'b0;
      if (load) begin
        shad_pat_d = pat_in;
        shad_pt_d  = points;
      end else if (pending_q) begin
        shad_pat_d = hold_pat_q;
        shad_pt_d  = hold_pt_q;
      end
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    phase = (enable && !blank) ? PhShow : PhBlank;
    lit   = (phase == PhShow);
`ifdef DISP_DIM_EN
    pwm_phase = 4'(cnt - CntW'(BLANK_CYCLES));
    lit       = lit && (pwm_phase <= bright);
`endif
    digit_d   = lit ? ~(NDIG'(1) << idx) : '1;
    segment_d = lit ? shad_pat_q[idx] : SEG_OFF;
    dp_d      = lit ? shad_pt_q[idx] : 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digit      <= '1;
      segment    <= SEG_OFF;
      dp         <= 1'b1;
      hold_pat_q <= '1;
      hold_pt_q  <= '1;
      shad_pat_q <= '1;
      shad_pt_q  <= '1;
      pending_q  <= 1'b0;
    end else begin
      digit      <= digit_d;
      segment    <= segment_d;
      dp         <= dp_d;
      hold_pat_q <= hold_pat_d;
      hold_pt_q  <= hold_pt_d;
      shad_pat_q <= shad_pat_d;
      shad_pt_q  <= shad_pt_d;
      pending_q  <= pending_d;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner: a time-based reference model predicts
// every output cycle from elapsed scan time and the frame-level load rules.
module tb_display_scanner;

  localparam int unsigned NDIG  = 4;
  localparam int unsigned BLANK = 4;
`ifdef DISP_DIM_EN
  localparam int unsigned DP = 36;
`else
  localparam int unsigned DP = 20;
`endif

  logic              clock    = 1'b0;
  logic              reset    = 1'b0;
  logic              enable   = 1'b0;
  logic              load     = 1'b0;
  logic [7*NDIG-1:0] patterns = '1;
  logic [NDIG-1:0]   points   = '1;
`ifdef DISP_DIM_EN
  logic [3:0]        bright   = 4'd15;
`endif
  logic [6:0]        segment;
  logic              dp;
  logic [NDIG-1:0]   digit;
  logic              frame_done;

  display_scanner #(
    .NDIG         (NDIG),
    .DIG_PERIOD   (DP),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .patterns   (patterns),
    .points     (points),
`ifdef DISP_DIM_EN
    .bright     (bright),
`endif
    .segment    (segment),
    .dp         (dp),
    .digit      (digit),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: t = cycles scanned since enable/reset; data per frame rules.
  int                t = 0;
  logic [7*NDIG-1:0] m_hold_pat = '1, m_sh_pat = '1;
  logic [NDIG-1:0]   m_hold_pt = '1, m_sh_pt = '1;
  bit                m_pend = 1'b0;
  logic [NDIG-1:0]   prev_lit = '1;
  int                dark_run = 0;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    m_hold_pat = '1;
    m_sh_pat   = '1;
    m_hold_pt  = '1;
    m_sh_pt    = '1;
    m_pend     = 1'b0;
  endtask

  task automatic tick();
    int              pos, di;
    bit              lit, fwrap;
    logic [NDIG-1:0] e_digit;
    logic [6:0]      e_seg;
    logic            e_dp, e_fd;
    pos = t % DP;
    di  = (t / DP) % NDIG;
    lit = enable && (pos >= BLANK);
`ifdef DISP_DIM_EN
    lit = lit && (((pos - BLANK) % 16) <= int'(bright));
`endif
    e_digit = lit ? ~(NDIG'(1) << di) : '1;
    e_seg   = lit ? m_sh_pat[di*7 +: 7] : 7'h7F;
    e_dp    = lit ? m_sh_pt[di] : 1'b1;
    e_fd    = enable && (pos == DP - 1) && (di == NDIG - 1);
    fwrap   = !enable || e_fd;
    if (fwrap) begin
      if (load) begin
        m_sh_pat = patterns;
        m_sh_pt  = points;
      end else if (m_pend) begin
        m_sh_pat = m_hold_pat;
        m_sh_pt  = m_hold_pt;
      end
      m_pend = 1'b0;
    end else if (load) begin
      m_pend = 1'b1;
    end
    if (load) begin
      m_hold_pat = patterns;
      m_hold_pt  = points;
    end
    t = enable ? t + 1 : 0;
    @(posedge clock);
    #1;
    chk("digit", digit, e_digit);
    chk("segment", segment, e_seg);
    chk("dp", dp, e_dp);
    chk("frame_done", frame_done, e_fd);
    chk("one_anode", ($countones(~digit) <= 1), 1);
    if (digit != '1) begin
      if (prev_lit != '1 && prev_lit != digit) chk("blank_gap", (dark_run >= BLANK), 1);
      prev_lit = digit;
      dark_run = 0;
    end else begin
      dark_run++;
    end
  endtask

  task automatic run_to(input int di, input int pos);
    for (int i = 0; i < NDIG * DP + 2; i++) begin
      if ((t % DP) == pos && ((t / DP) % NDIG) == di) return;
      tick();
    end
    checks++;
    errors++;
    $error("FAIL run_to observed=timeout expected=slot%0d/%0d", di, pos);
  endtask

  task automatic run_cycles(input int n, input int load_odds);
    for (int i = 0; i < n; i++) begin
      load = (load_odds > 0) && ($urandom_range(0, load_odds - 1) == 0);
      if (load) begin
        patterns = (7*NDIG)'($urandom());
        points   = NDIG'($urandom());
      end
      tick();
    end
    load = 1'b0;
  endtask

  initial begin
    // Reset state
    #2 reset = 1'b1;
    #1;
    chk("rst_digit", digit, 4'hF);
    chk("rst_segment", segment, 7'h7F);
    chk("rst_dp", dp, 1);
    chk("rst_frame_done", frame_done, 0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    model_reset();

    // First load: dark segments until frame wrap, then the new data
    enable   = 1'b1;
    load     = 1'b1;
    patterns = {7'h01, 7'h7E, 7'h18, 7'h08};
    points   = 4'b1110;
    tick();
    load = 1'b0;
    run_cycles(3 * NDIG * DP, 0);

    // Load A in slot 1, B in slot 2: next frame shows only B
    run_to(1, 7);
    load     = 1'b1;
    patterns = {4{7'h30}};
    points   = 4'b0101;
    tick();
    load = 1'b0;
    run_to(2, 7);
    load     = 1'b1;
    patterns = {4{7'h48}};
    points   = 4'b1010;
    tick();
    load = 1'b0;
    run_cycles(NDIG * DP, 0);

    // Load in the exact wrap cycle goes straight to the new frame
    run_to(NDIG - 1, DP - 1);
    load     = 1'b1;
    patterns = {7'h71, 7'h31, 7'h38, 7'h7E};
    points   = 4'b0110;
    tick();
    load = 1'b0;
    run_cycles(NDIG * DP, 0);

    // Randomized loads over several frames
    run_cycles(6 * NDIG * DP, 25);

    // Enable dropped mid-slot 2, loads while dark, then re-enable
    run_to(2, 10);
    enable = 1'b0;
    run_cycles(3 + int'($urandom_range(0, 5)), 2);
    enable = 1'b1;
    run_cycles(2 * NDIG * DP, 40);

    // Asynchronous reset during a SHOW phase
    run_to(1, 8);
    #2 reset = 1'b1;
    #1;
    chk("arst_digit", digit, 4'hF);
    chk("arst_segment", segment, 7'h7F);
    chk("arst_dp", dp, 1);
    model_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    run_cycles(2 * NDIG * DP, 0);
    load     = 1'b1;
    patterns = (7*NDIG)'($urandom());
    points   = NDIG'($urandom());
    tick();
    load = 1'b0;
    run_cycles(2 * NDIG * DP, 0);

`ifdef DISP_DIM_EN
    bright = 4'd3;
    run_cycles(NDIG * DP, 0);
    bright = 4'd15;
    run_cycles(NDIG * DP, 0);
    bright = 4'd0;
    run_cycles(NDIG * DP, 0);
    for (int i = 0; i < 2 * NDIG * DP; i++) begin
      bright = 4'($urandom());
      run_cycles(1, 30);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
